// File: rtl/truth_table_sweep.sv
// Applies all 16 vectors of a 4-input gate, captures its response into a truth
// table and compares the table against a golden value latched at start.
module truth_table_sweep #(
   parameter int SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] expected,
   input  logic        t_in,
   output logic        p,
   output logic        q,
   output logic        r,
   output logic        s,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] table_out,
   output logic [3:0]  mismatch_idx
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

   localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  wait_q, wait_d;
   logic [15:0] exp_q, exp_d;
   logic [15:0] table_q, table_d;
   logic        pass_q, pass_d;
   logic [3:0]  midx_q, midx_d;

   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] pos;
      pos = '0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) pos = 4'(i);
      end
      return pos;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         wait_q  <= '0;
         exp_q   <= '0;
         table_q <= '0;
         pass_q  <= 1'b0;
         midx_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         exp_q   <= exp_d;
         table_q <= table_d;
         pass_q  <= pass_d;
         midx_q  <= midx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_SETTLE;
         S_SETTLE:       if (wait_q == WAIT_LAST) state_d = S_SAMPLE;
         S_SAMPLE:       state_d = (idx_q == 4'd15) ? S_DONE : S_SETTLE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idx_d   = idx_q;
      wait_d  = wait_q;
      exp_d   = exp_q;
      table_d = table_q;
      pass_d  = pass_q;
      midx_d  = midx_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               exp_d   = expected;
               table_d = '0;
               idx_d   = '0;
               wait_d  = '0;
               pass_d  = 1'b0;
               midx_d  = '0;
            end
         end
         S_SETTLE: begin
            if (wait_q != WAIT_LAST) wait_d = wait_q + 4'd1;
         end
         S_SAMPLE: begin
            table_d[idx_q] = t_in;
            // The verdict uses table_d so the final bit-15 sample is included.
            if (idx_q == 4'd15) begin
               pass_d = (table_d == exp_q);
               midx_d = (table_d == exp_q) ? 4'd0 : lowest_set(table_d ^ exp_q);
            end else begin
               idx_d  = idx_q + 4'd1;
               wait_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy         = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
      done         = (state_q == S_DONE);
      {p, q, r, s} = busy ? idx_q : 4'b0000;
      pass         = pass_q;
      table_out    = table_q;
      mismatch_idx = midx_q;
   end

endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning the number of wait cycles after each vector is applied before t_in is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a 16-vector sweep.
REQ-005 The block SHALL have port expected, input, 16 bits: golden truth table, where bit i is the expected output for vector i.
REQ-006 The block SHALL have port t_in, input, 1 bit: output of the 4-input combinational gate under test.
REQ-007 The block SHALL have ports p, q, r, s, output, 1 bit each: the stimulus vector, with {p,q,r,s} = vector index and p as MSB.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: high while results are valid.
REQ-010 The block SHALL have port pass, output, 1 bit: high when the captured table equals the latched expected value; valid only when done=1.
REQ-011 The block SHALL have port table_out, output, 16 bits: captured truth table, where bit i = t_in sampled for vector i.
REQ-012 The block SHALL have port mismatch_idx, output, 4 bits: lowest vector index where captured != expected; 0 when pass=1.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, SETTLE, SAMPLE, DONE.
REQ-014 In IDLE with start=1 the block SHALL latch expected, clear table_out, set idx=0 and wait count=0, and go to SETTLE.
REQ-015 In SETTLE the block SHALL drive {p,q,r,s}=idx; if wait count == SETTLE-1, it goes to SAMPLE; otherwise it increments the wait count.
REQ-016 In SAMPLE the block SHALL write table_out[idx] <= t_in; if idx==15, it goes to DONE; otherwise it increments idx, clears the wait count and goes to SETTLE.
REQ-017 Each vector SHALL occupy exactly SETTLE+1 cycles, and {p,q,r,s} SHALL stay stable over all of those cycles.
REQ-018 done SHALL rise 16*(SETTLE+1) cycles after the clock edge that accepted start, which is 32 cycles for SETTLE=1.
REQ-019 busy SHALL be 1 in SETTLE and SAMPLE, and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-020 On entry to DONE, pass and mismatch_idx SHALL be computed from the final table, including the bit-15 sample, and be registered.
REQ-021 The block SHALL hold DONE and all results until start=1 or reset.
REQ-022 start=1 in DONE SHALL behave exactly as start in IDLE: immediate restart with the expected value latched anew.
REQ-023 start during SETTLE or SAMPLE SHALL be ignored, with no restart and no timing change.
REQ-024 Changes to expected after the start edge SHALL have no effect on the current sweep.
REQ-025 The index SHALL NOT wrap: after vector 15 the block goes to DONE, never back to vector 0.
REQ-026 In IDLE and DONE, {p,q,r,s} SHALL be driven to 4'b0000.
REQ-027 When more than one bit mismatches, mismatch_idx SHALL report the lowest index.

Reset
REQ-028 When rst_n=0 at a rising clk edge, the block SHALL go to IDLE and clear idx, the wait count, the latched expected value, table_out, mismatch_idx, pass, done, busy and p/q/r/s to 0.
REQ-029 Reset SHALL take priority over start in the same cycle.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep with no partial results retained; a following start SHALL begin again from vector 0.
REQ-031 rst_n SHALL have no effect between clock edges.

Verification
REQ-032 Reset: rst_n=0 for 1 edge -> busy=0, done=0, pass=0, table_out=16'h0000, {p,q,r,s}=0.
REQ-033 Nominal run: SETTLE=1, t_in modelled as pq'r's + rs', expected=16'h4644, start pulsed 1 cycle -> busy for 32 cycles, then done=1, table_out=16'h4644, pass=1, mismatch_idx=0.
REQ-034 Fail detection: same setup with expected=16'h4645 -> done=1, pass=0, table_out=16'h4644, mismatch_idx=0; repeat with expected=16'hC644 -> mismatch_idx=15.
REQ-035 Ignored start: start re-pulsed at cycle 10 of a sweep -> done still at cycle 32, results identical to the nominal run.
REQ-036 Mid-run reset: rst_n=0 while idx=7 -> next cycle state IDLE, table_out=0, {p,q,r,s}=0; a new start completes normally in 32 cycles.
REQ-037 Parameter sweep: SETTLE=3, t_in tied 1, expected=16'hFFFF -> each vector held 4 cycles, done at cycle 64, table_out=16'hFFFF, pass=1; restart from DONE via start -> busy=1 on the next cycle.
